enigma_cmd_decoder: RTL
=======================

// Module: enigma_cmd_decoder
// PURPOSE
//  Next-generation switch/button command front end for the Enigma datapath. Decodes a packed switch word
//  on each rising edge of the button strobe into rotor-config or letter commands. Buffers letters in a FIFO
//  and presents config and letters to the cipher core over ready/valid handshakes, so nothing is dropped.
//  Config never overtakes letters: letters entered before a config command are emitted before that config.
// PARAMETERS
//  NUM_ROTORS  3  rotor count; sets the width of the packed select and initial-position fields
//  ROTOR_ID_W  3  bits per rotor identifier
//  LETTER_W    5  bits per letter/position (A=0..Z=25)
//  FIFO_DEPTH  8  letter FIFO entries; power of two, >=2
//  Derived: DATA_W = max(NUM_ROTORS*LETTER_W, NUM_ROTORS*ROTOR_ID_W); CMD_W = DATA_W+2 (defaults 15/17)
// PORTS
//  clk_in             in   1                        system clock; the only clock
//  rst_in             in   1                        synchronous, active-high reset
//  data_valid_in      in   1                        button level (already synchronised); rising edge = command
//  sw                 in   CMD_W                    sw[CMD_W-1:CMD_W-2]=opcode, sw[DATA_W-1:0]=payload
//  rotor_select_out   out  NUM_ROTORS*ROTOR_ID_W    rotor IDs for the config transaction
//  rotor_initial_out  out  NUM_ROTORS*LETTER_W      initial rotor positions for the config transaction
//  cfg_valid_out      out  1                        config transaction offered
//  cfg_ready_in       in   1                        core accepts config
//  char_out           out  LETTER_W                 FIFO head letter
//  letter_valid_out   out  1                        letter offered
//  letter_ready_in    in   1                        core accepts letter
//  fifo_count_out     out  $clog2(FIFO_DEPTH)+1     FIFO occupancy
//  busy_out           out  1                        state != S_IDLE
//  err_out            out  1                        one-cycle error pulse
//  err_code_out       out  2                        last error code; held until next error
// BEHAVIOUR
//  Reset: every output 0; FIFO empty; shadow registers 0; prev-strobe register 0; state S_IDLE.
//  Command strobe: data_valid_in=1 while the registered previous value=0. Decode in that cycle; effects at
//  the next clock edge.
//  Opcodes:
//   00  load rotor_initial_out <= payload; request config
//   01  load rotor_select_out <= payload; request config
//   10  push payload[LETTER_W-1:0] into FIFO
//   11  flush FIFO (count -> 0); pending config is unaffected
//  FSM: S_IDLE -(cfg cmd)-> S_DRAIN -(FIFO empty)-> S_CFG -(cfg_valid_out & cfg_ready_in)-> S_IDLE.
//   S_DRAIN->S_CFG is evaluated every cycle, including the cycle after entry.
//   Earliest cfg_valid_out is strobe cycle N+2.
//  cfg_valid_out = (state==S_CFG). Hold it and both shadow fields stable until accepted.
//  letter_valid_out = FIFO non-empty && state!=S_CFG. char_out = FIFO head (first-word fall-through).
//   Pop on valid&ready. Letter strobe into an empty FIFO at N gives letter_valid_out at N+1.
//  Errors: pulse err_out and update err_code_out; the command is discarded.
//   01  letter push with FIFO full and no same-cycle pop. A push and pop in the same cycle is legal when full.
//   10  opcode 00/01/10 while state!=S_IDLE. Flush is always accepted.
//   11  letter out of range (only when the range-check macro is defined)
//  Flush in S_DRAIN moves to S_CFG on the next cycle. A flush and a pop in the same cycle: the flush wins.
//  The FIFO pointers wrap modulo FIFO_DEPTH. The count saturates at FIFO_DEPTH and never goes below 0.
//  Reset mid-transaction: drop cfg_valid_out and letter_valid_out the next cycle; discard all contents.
// CONFIGURATION
//  ENIGMA_LETTER_CHECK_EN
//   defined:     opcode 10 with payload >=26 is rejected (err 11); opcode 00 with any field >=26 is rejected (err 11).
//   not defined: all payloads are accepted unchecked; err code 11 is never produced.
// STRUCTURE
//  enigma_pkg: opcode enum (OP_INIT, OP_SEL, OP_LETTER, OP_FLUSH), err enum, state enum, ALPHABET_SIZE=26.
//  Sub-module letter_fifo (DEPTH, WIDTH params; push/pop/flush/full/empty/count; FWFT).
//  This module keeps the edge detect, decode, FSM and error logic.
// TESTING
//  Letters 3,7 (op 10) with letter_ready_in=1 -> char_out 3 then 7, each valid one cycle after its strobe.
//  letter_ready_in=0, push 9 letters (depth 8) -> count=8, 9th gives err_out pulse and code 01.
//  Push 2 letters with ready=0, then op 01 sel=0x0A3 -> busy_out=1, cfg_valid_out stays 0 until ready=1
//   drains both, then cfg_valid_out=1 with rotor_select_out=0x0A3.
//  cfg_ready_in=0 in S_CFG, letter strobe -> err code 10, FIFO unchanged, cfg fields stable.
//  With macro defined, letter 27 -> err code 11. Without it, 27 is emitted on char_out.
//  rst_in during S_CFG with 3 letters queued -> next cycle all outputs 0, count 0, S_IDLE.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types for the Enigma command front end: opcodes, error codes, FSM states.
package enigma_pkg;
  localparam int ALPHABET_SIZE = 26;

  typedef enum logic [1:0] {
    OP_INIT   = 2'b00,
    OP_SEL    = 2'b01,
    OP_LETTER = 2'b10,
    OP_FLUSH  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_FULL  = 2'b01,
    ERR_BUSY  = 2'b10,
    ERR_RANGE = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DRAIN = 2'b01,
    S_CFG   = 2'b10
  } state_e;

  function automatic logic out_of_alpha(input logic [31:0] v);
    return v >= 32'(ALPHABET_SIZE);
  endfunction
endpackage

// File: rtl/enigma_cmd_decoder_letter_fifo.sv
// First-word fall-through letter FIFO with flush; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module letter_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 5,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_do_push, w_do_pop;

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_count   = r_cnt;
  assign o_rdata   = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (rst_in || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_do_push && !i_flush) r_mem[r_wr] <= i_wdata;
  end
endmodule

// File: rtl/enigma_cmd_decoder.sv
// Switch/button command decoder feeding the Enigma core over ready/valid.
// Optional ENIGMA_LETTER_CHECK_EN rejects letters/positions outside A..Z (err 11).
module enigma_cmd_decoder
  import enigma_pkg::*;
#(
  parameter  int NUM_ROTORS = 3,
  parameter  int ROTOR_ID_W = 3,
  parameter  int LETTER_W   = 5,
  parameter  int FIFO_DEPTH = 8,
  localparam int SEL_W      = NUM_ROTORS * ROTOR_ID_W,
  localparam int INIT_W     = NUM_ROTORS * LETTER_W,
  localparam int DATA_W     = (INIT_W > SEL_W) ? INIT_W : SEL_W,
  localparam int CMD_W      = DATA_W + 2,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              data_valid_in,
  input  logic [CMD_W-1:0]  sw,
  output logic [SEL_W-1:0]  rotor_select_out,
  output logic [INIT_W-1:0] rotor_initial_out,
  output logic              cfg_valid_out,
  input  logic              cfg_ready_in,
  output logic [LETTER_W-1:0] char_out,
  output logic              letter_valid_out,
  input  logic              letter_ready_in,
  output logic [CNT_W-1:0]  fifo_count_out,
  output logic              busy_out,
  output logic              err_out,
  output logic [1:0]        err_code_out
);
  state_e              r_state, w_next;
  logic                r_prev;
  logic [SEL_W-1:0]    r_sel;
  logic [INIT_W-1:0]   r_init;
  logic                r_err;
  logic [1:0]          r_err_code;
  logic                w_strobe, w_pop, w_push, w_flush, w_ld_init, w_ld_sel;
  logic                w_err, w_range_bad, w_full, w_empty;
  err_e                w_err_code;
  opcode_e             w_op;
  logic [DATA_W-1:0]   w_payload;
  logic [LETTER_W-1:0] w_head;

  assign w_strobe  = data_valid_in & ~r_prev;
  assign w_op      = opcode_e'(sw[CMD_W-1:CMD_W-2]);
  assign w_payload = sw[DATA_W-1:0];
  assign w_pop     = letter_valid_out & letter_ready_in;

  letter_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(LETTER_W)) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (w_payload[LETTER_W-1:0]),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count_out)
  );

`ifdef ENIGMA_LETTER_CHECK_EN
  always_comb begin
    w_range_bad = 1'b0;
    if (w_op == OP_LETTER) w_range_bad = out_of_alpha(32'(w_payload));
    else if (w_op == OP_INIT)
      for (int i = 0; i < NUM_ROTORS; i++)
        if (out_of_alpha(32'(w_payload[i*LETTER_W +: LETTER_W]))) w_range_bad = 1'b1;
  end
`else
  assign w_range_bad = 1'b0;
`endif

  // Flush is always honoured; every other command needs S_IDLE.
  always_comb begin
    w_push = 1'b0; w_flush = 1'b0; w_ld_init = 1'b0; w_ld_sel = 1'b0;
    w_err = 1'b0; w_err_code = ERR_NONE;
    if (w_strobe) begin
      if (w_op == OP_FLUSH) w_flush = 1'b1;
      else if (r_state != S_IDLE) begin w_err = 1'b1; w_err_code = ERR_BUSY; end
      else if (w_range_bad) begin w_err = 1'b1; w_err_code = ERR_RANGE; end
      else if (w_op == OP_LETTER && w_full && !w_pop) begin w_err = 1'b1; w_err_code = ERR_FULL; end
      else begin
        w_ld_init = (w_op == OP_INIT);
        w_ld_sel  = (w_op == OP_SEL);
        w_push    = (w_op == OP_LETTER);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_ld_init || w_ld_sel) w_next = S_DRAIN;
      S_DRAIN: if (w_empty || w_flush)    w_next = S_CFG;
      S_CFG:   if (cfg_ready_in)          w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_valid_out    = (r_state == S_CFG);
    busy_out         = (r_state != S_IDLE);
    letter_valid_out = !w_empty && (r_state != S_CFG);
    char_out         = w_empty ? '0 : w_head;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_prev     <= 1'b0;
      r_sel      <= '0;
      r_init     <= '0;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_prev <= data_valid_in;
      r_err  <= w_err;
      if (w_err)     r_err_code <= w_err_code;
      if (w_ld_init) r_init     <= w_payload[INIT_W-1:0];
      if (w_ld_sel)  r_sel      <= w_payload[SEL_W-1:0];
    end
  end

  assign rotor_select_out  = r_sel;
  assign rotor_initial_out = r_init;
  assign err_out           = r_err;
  assign err_code_out      = r_err_code;
endmodule
